// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
// The ALU-control decoder imports the ALUOP_* values from here as well.
package mc_ctrl_pkg;

   localparam int OP_W    = 6;
   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;

   localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
   localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
   localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // Full control word for one state; pc_write and branch are merged into pc_en by the top.
   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state -> control-word decode for the main control FSM.
// Only FETCH looks at mem_ready: IR and PC load once the instruction word arrives.
module mc_out_decode
   import mc_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
            ctrl.alu_src_b = ALU_SRC_B_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
         end
         DECODE: begin
            ctrl.alu_src_b = ALU_SRC_B_IMM_SH2;
            ctrl.alu_op    = ALUOP_ADD;
         end
         MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_SRC_B_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         MEMREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         MEMWRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_SRC_B_REG;
            ctrl.alu_op    = ALUOP_RTYPE;
         end
         ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_SRC_B_REG;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.branch    = 1'b1;
            ctrl.pc_src    = PC_SRC_ALUOUT;
         end
         ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALU_SRC_B_IMM;
            ctrl.alu_op    = ALUOP_ADDI;
         end
         ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state logic, reset gating of
// the decoded control word, pc_en and the illegal-opcode pulse.
module mc_main_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_en,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         pc_src,
   output logic [1:0]         Alu_op,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_o
);

   state_t state;
   state_t next_state;
   ctrl_t  dec;
   ctrl_t  ctl;

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= next_state;
   end

   // Memory handshake: a request (mem_read/mem_write) is held constant while in FETCH,
   // MEMREAD or MEMWRITE; the transfer completes in the cycle mem_ready=1 and the FSM
   // leaves the wait state on that edge.
   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:    next_state = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = EXECUTE;
               OP_BEQ:       next_state = BRANCH;
               OP_ADDI:      next_state = ADDIEX;
               OP_J:         next_state = JUMP;
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:   next_state = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
         EXECUTE:  next_state = ALUWB;
         ADDIEX:   next_state = ADDIWB;
         default:  next_state = FETCH;
      endcase
   end

   mc_out_decode u_out_decode (
      .state     (state),
      .mem_ready (mem_ready),
      .ctrl      (dec)
   );

   // Reset suppresses every control output so an aborted instruction cannot write anything.
   always_comb begin
      ctl        = rst ? '0 : dec;
      pc_en      = ctl.pc_write | (ctl.branch & zero);
      i_or_d     = ctl.i_or_d;
      mem_read   = ctl.mem_read;
      mem_write  = ctl.mem_write;
      ir_write   = ctl.ir_write;
      reg_dst    = ctl.reg_dst;
      mem_to_reg = ctl.mem_to_reg;
      reg_write  = ctl.reg_write;
      alu_src_a  = ctl.alu_src_a;
      alu_src_b  = ctl.alu_src_b;
      pc_src     = ctl.pc_src;
      Alu_op     = ctl.alu_op;
      illegal_op = !rst && (state == DECODE) && !is_legal_op(opcode);
   end

   assign state_o = state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed scenarios plus randomized instruction streams
// checked against a phase-list model of each instruction.
module tb_mc_main_ctrl;

   localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMREAD = 4'd3;
   localparam logic [3:0] ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5, ST_EXECUTE = 4'd6, ST_ALUWB = 4'd7;
   localparam logic [3:0] ST_BRANCH = 4'd8, ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;

   localparam logic [5:0] C_R = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011;
   localparam logic [5:0] C_BEQ = 6'b000100, C_ADDI = 6'b001000, C_J = 6'b000010;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_src, Alu_op;
   logic [3:0] state_o;
   logic [15:0] obs;

   int checks = 0;
   int errors = 0;

   mc_main_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .Alu_op(Alu_op),
      .illegal_op(illegal_op), .state_o(state_o)
   );

   assign obs = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, pc_src, Alu_op, illegal_op};

   // Clock and reset-time input values
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
   end

   // Driver: apply inputs at the falling edge, settle, caller then samples outputs.
   task automatic drive(input logic r, input logic [5:0] op, input logic mr, input logic z);
      @(negedge clk);
      rst = r; opcode = op; mem_ready = mr; zero = z;
      #1;
   endtask

   // Expected control word for a phase, in the same bit order as obs.
   function automatic logic [15:0] exp_out(input logic [3:0] ph, input logic mr, input logic z,
                                           input logic [5:0] op);
      logic pc_write = 0, branch = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0;
      logic rw = 0, sa = 0, ill = 0;
      logic [1:0] sb = 0, ps = 0, ao = 0;
      case (ph)
         ST_FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pc_write = mr; end
         ST_DECODE:   begin sb = 2'b11; ill = !(op inside {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J}); end
         ST_MEMADR:   begin sa = 1; sb = 2'b10; end
         ST_MEMREAD:  begin mrd = 1; iod = 1; end
         ST_MEMWB:    begin rw = 1; m2r = 1; end
         ST_MEMWRITE: begin mwr = 1; iod = 1; end
         ST_EXECUTE:  begin sa = 1; ao = 2'b10; end
         ST_ALUWB:    begin rw = 1; rdst = 1; end
         ST_BRANCH:   begin sa = 1; ao = 2'b01; branch = 1; ps = 2'b01; end
         ST_ADDIEX:   begin sa = 1; sb = 2'b10; ao = 2'b11; end
         ST_ADDIWB:   begin rw = 1; end
         ST_JUMP:     begin pc_write = 1; ps = 2'b10; end
         default:     ;
      endcase
      return {pc_write | (branch & z), iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb, ps, ao, ill};
   endfunction

   // Runs one instruction from FETCH to its last phase. fixed_stall<0 picks random stalls in
   // the memory-wait phases; cycles returns the number of clocks spent.
   task automatic run_instr(input logic [5:0] op, input logic z, input int fixed_stall,
                            input string tag, output int cycles);
      logic [3:0] exp_q[$];
      logic [3:0] ph;
      logic       mr;
      int         stalls;
      bit         wait_ph;
      exp_q.push_back(ST_FETCH);
      exp_q.push_back(ST_DECODE);
      case (op)
         C_R:    begin exp_q.push_back(ST_EXECUTE); exp_q.push_back(ST_ALUWB); end
         C_LW:   begin exp_q.push_back(ST_MEMADR);  exp_q.push_back(ST_MEMREAD); exp_q.push_back(ST_MEMWB); end
         C_SW:   begin exp_q.push_back(ST_MEMADR);  exp_q.push_back(ST_MEMWRITE); end
         C_BEQ:  exp_q.push_back(ST_BRANCH);
         C_ADDI: begin exp_q.push_back(ST_ADDIEX);  exp_q.push_back(ST_ADDIWB); end
         C_J:    exp_q.push_back(ST_JUMP);
         default: ;
      endcase
      cycles = 0;
      while (exp_q.size() > 0) begin
         ph      = exp_q.pop_front();
         wait_ph = (ph == ST_FETCH) || (ph == ST_MEMREAD) || (ph == ST_MEMWRITE);
         stalls  = !wait_ph ? 0 : (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, 2));
         for (int s = 0; s <= stalls; s++) begin
            mr = wait_ph ? (s == stalls) : 1'($urandom_range(0, 1));
            drive(1'b0, op, mr, z);
            cycles++;
            checks++;
            if (state_o !== ph) begin
               errors++;
               $display("FAIL %s state: got %0d expected %0d (op=%b)", tag, state_o, ph, op);
            end
            checks++;
            if (obs !== exp_out(ph, mr, z, op)) begin
               errors++;
               $display("FAIL %s outputs in state %0d: got %h expected %h (op=%b mr=%b z=%b)",
                        tag, ph, obs, exp_out(ph, mr, z, op), op, mr, z);
            end
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 6'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (obs !== 16'h0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0000", obs);
         end
         checks++;
         if (state_o !== ST_FETCH) begin
            errors++;
            $display("FAIL reset state: got %0d expected 0", state_o);
         end
      end
      drive(1'b0, C_R, 1'b0, 1'b0);
      checks++;
      if (state_o !== ST_FETCH || mem_read !== 1'b1 || alu_src_b !== 2'b01 || pc_en !== 1'b0) begin
         errors++;
         $display("FAIL post_reset fetch: got state=%0d mem_read=%b alu_src_b=%b pc_en=%b expected 0 1 01 0",
                  state_o, mem_read, alu_src_b, pc_en);
      end
   endtask

   task automatic test_rtype();
      int cyc;
      run_instr(C_R, 1'b0, 0, "rtype", cyc);
   endtask

   task automatic test_lw_stall();
      int cyc;
      run_instr(C_LW, 1'b0, 3, "lw_stall", cyc);
      run_instr(C_SW, 1'b1, 3, "sw_stall", cyc);
   endtask

   task automatic test_branch();
      int cyc;
      run_instr(C_BEQ, 1'b1, 0, "beq_taken", cyc);
      run_instr(C_BEQ, 1'b0, 0, "beq_not_taken", cyc);
   endtask

   task automatic test_illegal();
      int cyc;
      run_instr(6'b111111, 1'b0, 0, "illegal", cyc);
      drive(1'b0, C_R, 1'b0, 1'b0);
      checks++;
      if (state_o !== ST_FETCH || reg_write !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL illegal_return: got state=%0d reg_write=%b mem_write=%b expected 0 0 0",
                  state_o, reg_write, mem_write);
      end
   endtask

   task automatic test_latency();
      logic [5:0] ops[6] = '{C_R, C_LW, C_SW, C_BEQ, C_J, C_ADDI};
      int         lat[6] = '{4, 5, 4, 3, 3, 4};
      int         cyc;
      for (int i = 0; i < 6; i++) begin
         run_instr(ops[i], 1'($urandom), 0, "latency", cyc);
         checks++;
         if (cyc !== lat[i]) begin
            errors++;
            $display("FAIL latency op=%b: got %0d cycles expected %0d", ops[i], cyc, lat[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] pre[3] = '{ST_FETCH, ST_DECODE, ST_EXECUTE};
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, C_R, 1'b1, 1'b0);
         checks++;
         if (state_o !== pre[i]) begin
            errors++;
            $display("FAIL reset_mid approach: got state %0d expected %0d", state_o, pre[i]);
         end
      end
      drive(1'b1, C_R, 1'b1, 1'b0);
      checks++;
      if (state_o !== ST_ALUWB || obs !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid aluwb: got state=%0d outputs=%h expected 7 0000", state_o, obs);
      end
      drive(1'b0, C_R, 1'b0, 1'b0);
      checks++;
      if (state_o !== ST_FETCH || obs !== exp_out(ST_FETCH, 1'b0, 1'b0, C_R)) begin
         errors++;
         $display("FAIL reset_mid recover: got state=%0d outputs=%h expected 0 %h",
                  state_o, obs, exp_out(ST_FETCH, 1'b0, 1'b0, C_R));
      end
   endtask

   task automatic test_random();
      logic [5:0] pool[8] = '{C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J, 6'b111111, 6'b000001};
      int         cyc;
      for (int n = 0; n < 60; n++)
         run_instr(pool[$urandom_range(0, 7)], 1'($urandom), -1, "random", cyc);
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_stall();
      test_branch();
      test_illegal();
      test_latency();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against an unexpected hang in the stimulus sequence.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
